// File: rtl/hyper_eot_classifier.sv
// Classifies HyperBus end-of-transfer pulses as read or write completions
// by tracking launched transfers in an in-order direction queue.
module hyper_eot_classifier #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             err_clr_i,
    input  logic             rx_evt_i,
    input  logic             tx_evt_i,
    input  logic             eot_i,
    output logic             rd_done_o,
    output logic             wr_done_o,
    output logic             amb_o,
    output logic [CNT_W-1:0] pending_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_err_o,
    output logic             unf_err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] r_q;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rd_done;
    logic             r_wr_done;
    logic             r_amb;
    logic             r_ovf;
    logic             r_unf;

    logic w_empty;
    logic w_full;
    logic w_push_req;
    logic w_pop;
    logic w_push_ok;
    logic w_ovf_set;
    logic w_unf_set;
    logic w_head;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_W'(DEPTH));
    assign w_push_req = rx_evt_i ^ tx_evt_i;
    assign w_pop      = eot_i & ~w_empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = ~clr_i & w_push_req & w_full & ~w_pop;
    assign w_unf_set  = ~clr_i & eot_i & w_empty;
    assign w_head     = r_q[r_rd_ptr];

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
            r_amb     <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_amb <= rx_evt_i & tx_evt_i;
            r_ovf <= (r_ovf & ~err_clr_i) | w_ovf_set;
            r_unf <= (r_unf & ~err_clr_i) | w_unf_set;
            if (clr_i) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_cnt     <= '0;
                r_rd_done <= 1'b0;
                r_wr_done <= 1'b0;
            end else begin
                r_rd_done <= w_pop & w_head;
                r_wr_done <= w_pop & ~w_head;
                if (w_push_ok) begin
                    r_q[r_wr_ptr] <= rx_evt_i;
                    r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push_ok, w_pop})
                    2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    assign rd_done_o = r_rd_done;
    assign wr_done_o = r_wr_done;
    assign amb_o     = r_amb;
    assign pending_o = r_cnt;
    assign empty_o   = w_empty;
    assign full_o    = w_full;
    assign ovf_err_o = r_ovf;
    assign unf_err_o = r_unf;

endmodule

// File: tb/tb_hyper_eot_classifier.sv
// Directed bench for hyper_eot_classifier: a queue-based reference model checked
// every cycle, plus hand-computed literal checks at key points.
module tb_hyper_eot_classifier;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             sys_clk_i = 1'b0;
    logic             rst_i     = 1'b1;
    logic             clr_i     = 1'b0;
    logic             err_clr_i = 1'b0;
    logic             rx_evt_i  = 1'b0;
    logic             tx_evt_i  = 1'b0;
    logic             eot_i     = 1'b0;
    logic             rd_done_o;
    logic             wr_done_o;
    logic             amb_o;
    logic [CNT_W-1:0] pending_o;
    logic             empty_o;
    logic             full_o;
    logic             ovf_err_o;
    logic             unf_err_o;

    hyper_eot_classifier #(.DEPTH(DEPTH)) dut (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .clr_i     (clr_i),
        .err_clr_i (err_clr_i),
        .rx_evt_i  (rx_evt_i),
        .tx_evt_i  (tx_evt_i),
        .eot_i     (eot_i),
        .rd_done_o (rd_done_o),
        .wr_done_o (wr_done_o),
        .amb_o     (amb_o),
        .pending_o (pending_o),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .ovf_err_o (ovf_err_o),
        .unf_err_o (unf_err_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: an ordered list of directions, retired oldest-first.
    bit mq[$];
    bit m_rd, m_wr, m_amb, m_ovf, m_unf;

    always @(posedge sys_clk_i) begin
        bit ovf_set, unf_set, h;
        if (rst_i) begin
            mq.delete();
            m_rd = 0; m_wr = 0; m_amb = 0; m_ovf = 0; m_unf = 0;
        end else begin
            ovf_set = 0;
            unf_set = 0;
            m_rd = 0;
            m_wr = 0;
            m_amb = rx_evt_i && tx_evt_i;
            if (clr_i) begin
                mq.delete();
            end else begin
                if (eot_i && mq.size() == 0) unf_set = 1;
                else if (eot_i) begin
                    h = mq.pop_front();
                    m_rd = h;
                    m_wr = !h;
                end
                if (rx_evt_i != tx_evt_i) begin
                    if (mq.size() < DEPTH) mq.push_back(rx_evt_i);
                    else ovf_set = 1;
                end
            end
            m_ovf = (m_ovf && !err_clr_i) || ovf_set;
            m_unf = (m_unf && !err_clr_i) || unf_set;
        end
    end

    always @(negedge sys_clk_i) begin
        if (chk_en) begin
            chk("m_rd_done", int'(rd_done_o), int'(m_rd));
            chk("m_wr_done", int'(wr_done_o), int'(m_wr));
            chk("m_amb",     int'(amb_o),     int'(m_amb));
            chk("m_pending", int'(pending_o), mq.size());
            chk("m_empty",   int'(empty_o),   int'(mq.size() == 0));
            chk("m_full",    int'(full_o),    int'(mq.size() == DEPTH));
            chk("m_ovf",     int'(ovf_err_o), int'(m_ovf));
            chk("m_unf",     int'(unf_err_o), int'(m_unf));
        end
    end

    // Drive one cycle of inputs, then return to idle just after the edge.
    task automatic step(input bit rst, input bit rx, input bit tx, input bit eot,
                        input bit clr, input bit eclr);
        rst_i = rst; rx_evt_i = rx; tx_evt_i = tx; eot_i = eot;
        clr_i = clr; err_clr_i = eclr;
        @(posedge sys_clk_i);
        #1;
        rst_i = 0; rx_evt_i = 0; tx_evt_i = 0; eot_i = 0; clr_i = 0; err_clr_i = 0;
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_pending", int'(pending_o), 0);
        chk("rst_empty",   int'(empty_o),   1);
        chk("rst_full",    int'(full_o),    0);

        // rx, tx, rx then three EOTs
        step(0, 1, 0, 0, 0, 0); chk("t1_p1", int'(pending_o), 1);
        step(0, 0, 1, 0, 0, 0); chk("t1_p2", int'(pending_o), 2);
        step(0, 1, 0, 0, 0, 0); chk("t1_p3", int'(pending_o), 3);
        step(0, 0, 0, 1, 0, 0); chk("t1_rd1", int'(rd_done_o), 1); chk("t1_p2b", int'(pending_o), 2);
        step(0, 0, 0, 1, 0, 0); chk("t1_wr2", int'(wr_done_o), 1); chk("t1_p1b", int'(pending_o), 1);
        step(0, 0, 0, 1, 0, 0); chk("t1_rd3", int'(rd_done_o), 1); chk("t1_p0", int'(pending_o), 0);
        step(0, 0, 0, 0, 0, 0); chk("t1_rd_off", int'(rd_done_o), 0);

        // overflow on the fifth write launch
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
        chk("t2_full", int'(full_o), 1);
        chk("t2_ovf0", int'(ovf_err_o), 0);
        step(0, 0, 1, 0, 0, 0);
        chk("t2_ovf1", int'(ovf_err_o), 1);
        chk("t2_p4", int'(pending_o), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0, 0);
            chk("t2_wr", int'(wr_done_o), 1);
        end
        chk("t2_empty", int'(empty_o), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t2_ovf_clr", int'(ovf_err_o), 0);

        // full queue with simultaneous read launch and EOT
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        chk("t3_wr", int'(wr_done_o), 1);
        chk("t3_p4", int'(pending_o), 4);
        chk("t3_ovf", int'(ovf_err_o), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        chk("t3_wr_last", int'(wr_done_o), 1);
        step(0, 0, 0, 1, 0, 0);
        chk("t3_rd_last", int'(rd_done_o), 1);
        chk("t3_empty", int'(empty_o), 1);

        // EOT on empty together with a write launch
        step(0, 0, 1, 1, 0, 0);
        chk("t4_unf", int'(unf_err_o), 1);
        chk("t4_nodone", int'(rd_done_o | wr_done_o), 0);
        chk("t4_p1", int'(pending_o), 1);
        step(0, 0, 0, 1, 0, 0);
        chk("t4_wr", int'(wr_done_o), 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t4_unf_clr", int'(unf_err_o), 0);

        // ambiguous launch
        step(0, 1, 1, 0, 0, 0);
        chk("t5_amb", int'(amb_o), 1);
        chk("t5_p0", int'(pending_o), 0);
        step(0, 0, 0, 1, 0, 0);
        chk("t5_amb_off", int'(amb_o), 0);
        chk("t5_unf", int'(unf_err_o), 1);

        // flush with EOT, then reset mid-stream
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("t6_nodone", int'(rd_done_o | wr_done_o), 0);
        chk("t6_p0", int'(pending_o), 0);
        chk("t6_unf_kept", int'(unf_err_o), 1);
        step(0, 1, 1, 0, 1, 0);
        chk("t6_amb_clr", int'(amb_o), 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        chk("t6_rst_p", int'(pending_o), 0);
        chk("t6_rst_unf", int'(unf_err_o), 0);
        chk("t6_rst_amb", int'(amb_o), 0);
        chk("t6_rst_empty", int'(empty_o), 1);
        step(0, 0, 0, 0, 0, 0);
        @(negedge sys_clk_i);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
